// File: rtl/ram_fifo_pkg.sv
// Shared state encoding and default sizing for the RAM-backed FIFO controller.
`timescale 1ns/1ps
package ram_fifo_pkg;

  localparam int ADDR_SIZE_DEF   = 10;
  localparam int WORD_SIZE_DEF   = 8;
  localparam int MEMORY_SIZE_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WSETUP  = 3'd1,
    WSTROBE = 3'd2,
    WHOLD   = 3'd3,
    RSETUP  = 3'd4,
    RDONE   = 3'd5
  } state_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external level-sensitive single-port RAM.
// Each write uses a setup/strobe/hold sequence; each read uses setup/done.
`timescale 1ns/1ps
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int addr_size   = ADDR_SIZE_DEF,
  parameter int word_size   = WORD_SIZE_DEF,
  parameter int memory_size = MEMORY_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [word_size-1:0] push_data,
  output logic                 push_ready,
  input  logic                 pop,
  output logic [word_size-1:0] pop_data,
  output logic                 pop_valid,
  output logic                 full,
  output logic                 empty,
  output logic [addr_size:0]   count,
  output logic                 ovf,
  output logic                 udf,
  output logic [addr_size-1:0] ram_addr,
  output logic [word_size-1:0] ram_data_in,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [word_size-1:0] ram_data_out
);

  localparam logic [addr_size:0] C_FULL = (addr_size+1)'(memory_size);

  state_e               r_state;
  state_e               w_next;
  logic [addr_size-1:0] r_wr_ptr;
  logic [addr_size-1:0] r_rd_ptr;
  logic [addr_size:0]   r_count;
  logic [addr_size-1:0] r_ram_addr;
  logic [word_size-1:0] r_ram_data_in;
  logic [word_size-1:0] r_pop_data;
  logic                 r_ram_wr;
  logic                 r_ram_cs;
  logic                 r_pop_valid;
  logic                 r_ovf;
  logic                 r_udf;
  logic                 r_rr_pop;

  logic w_idle;
  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_grant_push;
  logic w_grant_pop;

  assign w_idle    = (r_state == IDLE);
  assign w_full    = (r_count == C_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push && w_idle && !w_full;
  assign w_pop_ok  = pop  && w_idle && !w_empty;

  // On contention r_rr_pop says which side wins; otherwise the lone requester wins.
  assign w_grant_push = w_push_ok && (!w_pop_ok || !r_rr_pop);
  assign w_grant_pop  = w_pop_ok && !w_grant_push;

  // NOTE: w_next gets a default before the case so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_push)     w_next = WSETUP;
        else if (w_grant_pop) w_next = RSETUP;
      end
      WSETUP:  w_next = WSTROBE;
      WSTROBE: w_next = WHOLD;
      WHOLD:   w_next = IDLE;
      RSETUP:  w_next = RDONE;
      RDONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_pop_data    <= '0;
      r_ram_wr      <= 1'b0;
      r_ram_cs      <= 1'b0;
      r_pop_valid   <= 1'b0;
      r_ovf         <= 1'b0;
      r_udf         <= 1'b0;
      r_rr_pop      <= 1'b1;
    end else begin
      r_state     <= w_next;
      // Strobes are registered from the next state so they never glitch.
      r_ram_wr    <= (w_next == WSTROBE);
      r_ram_cs    <= (w_next != IDLE);
      r_pop_valid <= (w_next == RDONE);
      r_ovf       <= push && w_idle && w_full;
      r_udf       <= pop  && w_idle && w_empty;

      if (w_push_ok && w_pop_ok) r_rr_pop <= w_grant_push;

      if (w_grant_push) begin
        r_ram_addr    <= r_wr_ptr;
        r_ram_data_in <= push_data;
      end else if (w_grant_pop) begin
        r_ram_addr <= r_rd_ptr;
      end

      if (r_state == RSETUP) r_pop_data <= ram_data_out;

      if (r_state == WHOLD) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end else if (r_state == RDONE) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= r_count - 1'b1;
      end
    end
  end

  assign push_ready  = w_idle && !w_full;
  assign pop_data    = r_pop_data;
  assign pop_valid   = r_pop_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign ovf         = r_ovf;
  assign udf         = r_udf;
  assign ram_addr    = r_ram_addr;
  assign ram_data_in = r_ram_data_in;
  assign ram_wr      = r_ram_wr;
  assign ram_cs      = r_ram_cs;

endmodule
